// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with PC register and IF/ID pipeline register
// Ports: clk/rst (sync, active-high); pc_stall_en holds PC; IFID_Wr enables IF/ID load;
//        redirect_en/redirect_pc steer PC and flush IF/ID; imem_addr/imem_rdata form the
//        async-read instruction-memory port; IFID_* feed ID; pc is the current fetch PC.
// Optional: define IF_STAGE_PERF_CNT_EN to add stall_cnt/flush_cnt outputs.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_stall_en,
    input  logic        IFID_Wr,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_pc,
    output logic [31:0] IFID_pc_plus4,
    output logic [31:0] IFID_inst,
    output logic        IFID_valid,
`ifdef IF_STAGE_PERF_CNT_EN
    output logic [31:0] pc,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`else
    output logic [31:0] pc
`endif
);
    logic [31:0] pc_plus4;
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            IFID_pc       <= '0;
            IFID_pc_plus4 <= '0;
            IFID_inst     <= NOP_INST;
            IFID_valid    <= 1'b0;
        end else begin
            pc <= redirect_en ? {redirect_pc[31:2], 2'b00} : pc_stall_en ? pc : pc_plus4;
            // a redirect flushes even a stalled ID slot: that instruction is wrong-path
            if (redirect_en) begin
                IFID_pc       <= '0;
                IFID_pc_plus4 <= '0;
                IFID_inst     <= NOP_INST;
                IFID_valid    <= 1'b0;
            end else if (IFID_Wr) begin
                IFID_pc       <= pc;
                IFID_pc_plus4 <= pc_plus4;
                IFID_inst     <= imem_rdata;
                IFID_valid    <= 1'b1;
            end
        end
    end
`ifdef IF_STAGE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, pc_stall_en & ~redirect_en};
            flush_cnt <= flush_cnt + {31'd0, redirect_en};
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_stall_en = 1'b0;
    logic        IFID_Wr = 1'b1;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_rdata, IFID_pc, IFID_pc_plus4, IFID_inst, pc;
    logic        IFID_valid;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst), .pc_stall_en(pc_stall_en), .IFID_Wr(IFID_Wr),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .IFID_pc(IFID_pc), .IFID_pc_plus4(IFID_pc_plus4), .IFID_inst(IFID_inst),
        .IFID_valid(IFID_valid),
`ifdef IF_STAGE_PERF_CNT_EN
        .pc(pc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
        .pc(pc)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    typedef struct {
        logic [31:0] pc, ipc, ip4, inst;
        logic        valid;
    } exp_t;

    typedef struct {
        logic        r, s, w, d;
        logic [31:0] t;
    } stim_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_pc = '0, m_ipc = '0, m_ip4 = '0, m_inst = '0;
    logic        m_valid = 1'b0;

    // apply one cycle of controls, advance the reference model, queue its expectation
    task automatic drive(input stim_t st);
        @(negedge clk);
        rst = st.r; pc_stall_en = st.s; IFID_Wr = st.w; redirect_en = st.d; redirect_pc = st.t;
        if (st.r) begin
            m_pc = RESET_PC; m_ipc = '0; m_ip4 = '0; m_inst = NOP_INST; m_valid = 1'b0;
        end else begin
            if (st.d) begin
                m_ipc = '0; m_ip4 = '0; m_inst = NOP_INST; m_valid = 1'b0;
            end else if (st.w) begin
                m_ipc = m_pc; m_ip4 = m_pc + 32'd4; m_inst = mem(m_pc); m_valid = 1'b1;
            end
            m_pc = st.d ? {st.t[31:2], 2'b00} : st.s ? m_pc : m_pc + 32'd4;
        end
        sb.push_back('{m_pc, m_ipc, m_ip4, m_inst, m_valid});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        stim_t st[2] = '{'{1'b1, 1'b0, 1'b1, 1'b0, 32'h0}, '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0}};
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            total++;
            if ({pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid} !== {e.pc, e.pc, e.ipc, e.ip4, e.inst, e.valid}) begin
                bad++;
                $display("FAIL reset[%0d]: got pc=%h addr=%h ifpc=%h ifp4=%h inst=%h v=%b want pc=%h ifpc=%h ifp4=%h inst=%h v=%b", i, pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid, e.pc, e.ipc, e.ip4, e.inst, e.valid);
            end
        end
        total++;
        if (pc !== 32'h3000 || IFID_valid !== 1'b0 || IFID_inst !== NOP_INST) begin
            bad++;
            $display("FAIL reset_const: got pc=%h v=%b inst=%h want pc=00003000 v=0 inst=%h", pc, IFID_valid, IFID_inst, NOP_INST);
        end
    endtask

    task automatic test_free_run;
        stim_t st[3] = '{'{1'b0, 1'b0, 1'b1, 1'b0, 32'h0}, '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0}, '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0}};
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            total++;
            if ({pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid} !== {e.pc, e.pc, e.ipc, e.ip4, e.inst, e.valid}) begin
                bad++;
                $display("FAIL free_run[%0d]: got pc=%h addr=%h ifpc=%h ifp4=%h inst=%h v=%b want pc=%h ifpc=%h ifp4=%h inst=%h v=%b", i, pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid, e.pc, e.ipc, e.ip4, e.inst, e.valid);
            end
            total++;
            if (pc !== 32'h3004 + 32'(4 * i) || IFID_pc !== 32'h3000 + 32'(4 * i) || IFID_valid !== 1'b1) begin
                bad++;
                $display("FAIL free_run_const[%0d]: got pc=%h ifpc=%h v=%b want pc=%h ifpc=%h v=1", i, pc, IFID_pc, IFID_valid, 32'h3004 + 32'(4 * i), 32'h3000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall;
        stim_t st[2] = '{'{1'b0, 1'b1, 1'b0, 1'b0, 32'h0}, '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0}};
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            total++;
            if ({pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid} !== {e.pc, e.pc, e.ipc, e.ip4, e.inst, e.valid}) begin
                bad++;
                $display("FAIL stall[%0d]: got pc=%h addr=%h ifpc=%h ifp4=%h inst=%h v=%b want pc=%h ifpc=%h ifp4=%h inst=%h v=%b", i, pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid, e.pc, e.ipc, e.ip4, e.inst, e.valid);
            end
        end
        total++;
        if (pc !== 32'h3010 || IFID_pc !== 32'h300C || IFID_inst !== mem(32'h300C)) begin
            bad++;
            $display("FAIL stall_resume: got pc=%h ifpc=%h inst=%h want pc=00003010 ifpc=0000300c inst=%h", pc, IFID_pc, IFID_inst, mem(32'h300C));
        end
    endtask

    task automatic test_redirect;
        stim_t st[2] = '{'{1'b0, 1'b0, 1'b1, 1'b1, 32'h3100}, '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0}};
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            total++;
            if ({pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid} !== {e.pc, e.pc, e.ipc, e.ip4, e.inst, e.valid}) begin
                bad++;
                $display("FAIL redirect[%0d]: got pc=%h addr=%h ifpc=%h ifp4=%h inst=%h v=%b want pc=%h ifpc=%h ifp4=%h inst=%h v=%b", i, pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid, e.pc, e.ipc, e.ip4, e.inst, e.valid);
            end
            if (i == 0) begin
                total++;
                if (pc !== 32'h3100 || IFID_inst !== NOP_INST || IFID_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL redirect_flush: got pc=%h inst=%h v=%b want pc=00003100 inst=%h v=0", pc, IFID_inst, IFID_valid, NOP_INST);
                end
            end
        end
        total++;
        if (IFID_pc !== 32'h3100 || IFID_valid !== 1'b1 || IFID_inst !== mem(32'h3100)) begin
            bad++;
            $display("FAIL redirect_target: got ifpc=%h v=%b inst=%h want ifpc=00003100 v=1 inst=%h", IFID_pc, IFID_valid, IFID_inst, mem(32'h3100));
        end
    endtask

    task automatic test_redirect_stall;
        stim_t st[2] = '{'{1'b0, 1'b1, 1'b0, 1'b1, 32'h3203}, '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0}};
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            total++;
            if ({pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid} !== {e.pc, e.pc, e.ipc, e.ip4, e.inst, e.valid}) begin
                bad++;
                $display("FAIL redirect_stall[%0d]: got pc=%h addr=%h ifpc=%h ifp4=%h inst=%h v=%b want pc=%h ifpc=%h ifp4=%h inst=%h v=%b", i, pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid, e.pc, e.ipc, e.ip4, e.inst, e.valid);
            end
            if (i == 0) begin
                total++;
                if (pc !== 32'h3200 || IFID_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL redirect_stall_const: got pc=%h v=%b want pc=00003200 v=0", pc, IFID_valid);
                end
            end
        end
    endtask

    task automatic test_wrap_reset;
        stim_t st[5] = '{'{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE}, '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0},
                         '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0}, '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0},
                         '{1'b1, 1'b1, 1'b0, 1'b1, 32'h4444}};
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            total++;
            if ({pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid} !== {e.pc, e.pc, e.ipc, e.ip4, e.inst, e.valid}) begin
                bad++;
                $display("FAIL wrap_reset[%0d]: got pc=%h addr=%h ifpc=%h ifp4=%h inst=%h v=%b want pc=%h ifpc=%h ifp4=%h inst=%h v=%b", i, pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid, e.pc, e.ipc, e.ip4, e.inst, e.valid);
            end
            if (i == 1) begin
                total++;
                if (pc !== 32'h0 || IFID_pc !== 32'hFFFF_FFFC || IFID_pc_plus4 !== 32'h0) begin
                    bad++;
                    $display("FAIL wrap_const: got pc=%h ifpc=%h ifp4=%h want pc=00000000 ifpc=fffffffc ifp4=00000000", pc, IFID_pc, IFID_pc_plus4);
                end
            end
        end
        total++;
        if (pc !== 32'h3000 || IFID_valid !== 1'b0 || IFID_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: got pc=%h v=%b ifpc=%h want pc=00003000 v=0 ifpc=00000000", pc, IFID_valid, IFID_pc);
        end
    endtask

`ifdef IF_STAGE_PERF_CNT_EN
    task automatic test_perf;
        stim_t st[7] = '{'{1'b1, 1'b0, 1'b1, 1'b0, 32'h0}, '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0},
                         '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0}, '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0},
                         '{1'b0, 1'b0, 1'b1, 1'b1, 32'h3400}, '{1'b0, 1'b1, 1'b0, 1'b1, 32'h3500},
                         '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0}};
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            total++;
            if ({pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid} !== {e.pc, e.pc, e.ipc, e.ip4, e.inst, e.valid}) begin
                bad++;
                $display("FAIL perf[%0d]: got pc=%h addr=%h ifpc=%h ifp4=%h inst=%h v=%b want pc=%h ifpc=%h ifp4=%h inst=%h v=%b", i, pc, imem_addr, IFID_pc, IFID_pc_plus4, IFID_inst, IFID_valid, e.pc, e.ipc, e.ip4, e.inst, e.valid);
            end
            if (i == 0) begin
                total++;
                if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
                    bad++;
                    $display("FAIL perf_reset: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
                end
            end
        end
        total++;
        if (stall_cnt !== 32'd3 || flush_cnt !== 32'd2) begin
            bad++;
            $display("FAIL perf_cnt: got stall=%0d flush=%0d want 3 2", stall_cnt, flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_free_run;
        test_stall;
        test_redirect;
        test_redirect_stall;
        test_wrap_reset;
`ifdef IF_STAGE_PERF_CNT_EN
        test_perf;
`endif
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the ID stage and the hazard detection unit.
- Holds the PC and drives the instruction-memory address. It latches {pc, pc+4, inst, valid} into IF/ID.
- Obeys the load-use stall controls (pc_stall_en, IFID_Wr) from hazard detection.
- Obeys the taken-branch/jump redirect resolved downstream, which flushes the wrong-path instruction.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_stall_en  input  1  hold PC this cycle (load-use stall).
- IFID_Wr  input  1  1 = IF/ID register loads; 0 = IF/ID holds.
- redirect_en  input  1  taken branch/jump/jr/jalr resolved downstream; PC must change.
- redirect_pc  input  32  target PC for redirect.
- imem_addr  output  32  instruction-memory address; equals pc (combinational).
- imem_rdata  input  32  instruction word at imem_addr, valid same cycle (asynchronous-read IM).
- IFID_pc  output  32  PC of instruction in ID.
- IFID_pc_plus4  output  32  IFID_pc + 4.
- IFID_inst  output  32  instruction in ID.
- IFID_valid  output  1  0 = bubble (reset/flush), 1 = real instruction.
- pc  output  32  current fetch PC (debug/trace).

Behaviour:
- Reset (rst=1 at posedge) has top priority:
  - pc <= RESET_PC.
  - IFID_pc <= 0, IFID_pc_plus4 <= 0, IFID_inst <= NOP_INST, IFID_valid <= 0.
  - Applies mid-stall and mid-redirect alike; no stall or redirect state survives reset.
- PC update priority below reset: redirect_en > pc_stall_en > sequential.
  - redirect_en=1: pc <= {redirect_pc[31:2],2'b00}. Low two bits are forced to zero.
  - Else pc_stall_en=1: pc holds.
  - Else pc <= pc + 4. Arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- IF/ID update priority below reset: redirect_en > IFID_Wr.
  - redirect_en=1 (flush): IFID_inst <= NOP_INST, IFID_valid <= 0, IFID_pc <= 0, IFID_pc_plus4 <= 0.
  - Flush wins even when IFID_Wr=0, because the stalled ID instruction is wrong-path.
  - Else IFID_Wr=1: IFID_pc <= pc, IFID_pc_plus4 <= pc+4, IFID_inst <= imem_rdata, IFID_valid <= 1.
  - Else IFID_Wr=0: all IF/ID fields hold.
- Latency:
  - Instruction fetched at cycle N appears on IFID_* at cycle N+1.
  - Redirect asserted at cycle N fetches the target at cycle N+1, which is visible in IF/ID at cycle N+2.
  - There is exactly one bubble from this block; downstream handles other flushes.
- Inconsistent controls:
  - pc_stall_en=1 with IFID_Wr=1: PC holds, IF/ID reloads the same fetch. This is a duplicate, not an error.
  - pc_stall_en=0 with IFID_Wr=0: PC advances, IF/ID holds, and the fetched word is dropped. This is legal but the hazard unit never produces it.
- No state machine beyond PC/IF/ID registers. There are no combinational paths from IF/ID outputs back to imem_addr.
- imem_addr = pc at all times, including during reset assertion.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- When defined, adds 32-bit outputs stall_cnt and flush_cnt.
  - stall_cnt increments each cycle with pc_stall_en=1 && redirect_en=0 && rst=0.
  - flush_cnt increments each cycle with redirect_en=1 && rst=0.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then free run:
  - rst=1 for 2 cycles, then 0, imem returns addr-based words.
  - Required: pc = 3000, 3004, 3008 on successive cycles.
  - Required: IFID_pc lags by one cycle, IFID_valid=0 in the first post-reset cycle and 1 thereafter, IFID_pc_plus4 = IFID_pc+4.
- Load-use stall:
  - With pc=300C, assert pc_stall_en=1, IFID_Wr=0 for one cycle.
  - Required: pc stays 300C one extra cycle and IF/ID holds the 3008 instruction for two cycles.
  - Required: the sequence resumes 3010 with no instruction lost or duplicated.
- Redirect:
  - With pc=3010, assert redirect_en=1, redirect_pc=32'h0000_3100.
  - Required next cycle: pc=3100, IFID_inst=NOP_INST, IFID_valid=0.
  - Required the cycle after: IFID_pc=3100, IFID_valid=1.
- Redirect during stall:
  - Assert redirect_en=1, pc_stall_en=1, IFID_Wr=0 together, redirect_pc=32'h0000_3203.
  - Required: pc=3200 (bits [1:0] cleared) and IF/ID flushed (valid=0).
- Wrap and reset mid-operation:
  - Force redirect to FFFF_FFFC; required: next pc is 0000_0000.
  - Assert rst during a stall; required: pc=3000 and IFID_valid=0 on the next edge.
- With IF_STAGE_PERF_CNT_EN defined:
  - Stimulus: 3 stall cycles, 2 redirects, one of which overlaps a stall.
  - Required: stall_cnt=3, flush_cnt=2.
